// File: rtl/mem_stage.sv
// Memory-access stage: ALU pass-through, or one outstanding load/store over a req/ack port.
// Optional byte accesses (lane select, sign-extended loads, byte enables) under `MEM_BYTE_EN.
module mem_stage #(
  parameter int REG_SIZE  = 32,
  parameter int ADDR_SIZE = 32,
  parameter int REG_ADDR  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 regwrite_in,
  input  logic                 memread,
  input  logic                 memwrite,
  input  logic [REG_SIZE-1:0]  aluresult,
  input  logic [REG_SIZE-1:0]  store_data,
  input  logic [REG_ADDR-1:0]  wreg_in,
`ifdef MEM_BYTE_EN
  input  logic                 byte_op,
`endif
  output logic                 stall,
  output logic                 regwrite_out,
  output logic [REG_ADDR-1:0]  wreg_out,
  output logic [REG_SIZE-1:0]  memresult,
  output logic                 misaligned,
  output logic                 mem_enable,
  output logic                 mem_rw,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [REG_SIZE-1:0]  mem_data_in,
`ifdef MEM_BYTE_EN
  output logic [3:0]           mem_be,
`endif
  input  logic [REG_SIZE-1:0]  mem_data_out,
  input  logic                 mem_ack,
  output logic                 dbg_state_o
);

  // Memory handshake: mem_enable rises with a request and stays high, with
  // mem_rw/mem_addr/mem_data_in/mem_be stable, until the cycle mem_ack is seen
  // high; the request completes on that edge. Acks seen while idle are ignored.
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t                state_q;
  logic                  regwrite_q;
  logic [REG_ADDR-1:0]   wreg_q;
  logic [REG_SIZE-1:0]   memresult_q;
  logic                  misaligned_q;
  logic                  mem_enable_q;
  logic                  mem_rw_q;
  logic [ADDR_SIZE-1:0]  mem_addr_q;
  logic [REG_SIZE-1:0]   mem_data_in_q;
  logic                  load_q;
  logic [REG_ADDR-1:0]   wreg_lat_q;

  logic                  memop;
  logic                  byte_acc;
  logic                  aligned;
  logic                  accept;
  logic [ADDR_SIZE-1:0]  mem_addr_d;
  logic [REG_SIZE-1:0]   mem_data_in_d;
  logic [REG_SIZE-1:0]   rdata_d;

`ifdef MEM_BYTE_EN
  logic                  byte_q;
  logic [1:0]            lane_q;
  logic [3:0]            mem_be_q;
  logic [3:0]            mem_be_d;
  logic [7:0]            rbyte;
`endif

  assign memop = valid_in & (memread | memwrite);

`ifdef MEM_BYTE_EN
  assign byte_acc = byte_op;
`else
  assign byte_acc = 1'b0;
`endif

  assign aligned = byte_acc | (aluresult[1:0] == 2'b00);
  assign accept  = (state_q == S_IDLE) & memop & aligned;
  assign stall   = accept | ((state_q == S_WAIT) & ~mem_ack);

  always_comb begin
    mem_addr_d    = ADDR_SIZE'(aluresult);
    mem_addr_d[1:0] = 2'b00;
    mem_data_in_d = store_data;
    rdata_d       = mem_data_out;
`ifdef MEM_BYTE_EN
    mem_be_d = 4'b1111;
    rbyte    = mem_data_out[{lane_q, 3'b000} +: 8];
    if (byte_op) begin
      mem_be_d      = 4'b0001 << aluresult[1:0];
      mem_data_in_d = {(REG_SIZE/8){store_data[7:0]}};
    end
    // Byte loads return the addressed lane, sign-extended to a full word.
    if (byte_q) begin
      rdata_d = {{(REG_SIZE-8){rbyte[7]}}, rbyte};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      regwrite_q    <= 1'b0;
      wreg_q        <= '0;
      memresult_q   <= '0;
      misaligned_q  <= 1'b0;
      mem_enable_q  <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      load_q        <= 1'b0;
      wreg_lat_q    <= '0;
`ifdef MEM_BYTE_EN
      byte_q        <= 1'b0;
      lane_q        <= 2'b00;
      mem_be_q      <= 4'b0000;
`endif
    end else begin
      regwrite_q   <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_in && !memop) begin
            regwrite_q  <= regwrite_in;
            memresult_q <= aluresult;
            wreg_q      <= wreg_in;
          end else if (memop && !aligned) begin
            misaligned_q <= 1'b1;
          end else if (accept) begin
            state_q       <= S_WAIT;
            mem_enable_q  <= 1'b1;
            mem_rw_q      <= ~memread;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            load_q        <= memread;
            wreg_lat_q    <= wreg_in;
`ifdef MEM_BYTE_EN
            byte_q        <= byte_op;
            lane_q        <= aluresult[1:0];
            mem_be_q      <= mem_be_d;
`endif
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            state_q      <= S_IDLE;
            mem_enable_q <= 1'b0;
            if (load_q) begin
              regwrite_q  <= 1'b1;
              memresult_q <= rdata_d;
              wreg_q      <= wreg_lat_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign regwrite_out = regwrite_q;
  assign wreg_out     = wreg_q;
  assign memresult    = memresult_q;
  assign misaligned   = misaligned_q;
  assign mem_enable   = mem_enable_q;
  assign mem_rw       = mem_rw_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_data_in_q;
`ifdef MEM_BYTE_EN
  assign mem_be       = mem_be_q;
`endif
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vectors, write-back scoreboard with a negedge monitor.
// Byte-access vectors are included when MEM_BYTE_EN is defined.
module tb_mem_stage;
  localparam int RS = 32;
  localparam int AS = 32;
  localparam int RA = 5;
  localparam int W  = RA + RS;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in, regwrite_in, memread, memwrite;
  logic [RS-1:0] aluresult, store_data;
  logic [RA-1:0] wreg_in;
  logic          stall, regwrite_out, misaligned, mem_enable, mem_rw;
  logic [RA-1:0] wreg_out;
  logic [RS-1:0] memresult, mem_data_in, mem_data_out;
  logic [AS-1:0] mem_addr;
  logic          mem_ack;
  logic          dbg_state_o;
`ifdef MEM_BYTE_EN
  logic          byte_op;
  logic [3:0]    mem_be;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  int exp_mis = 0;

  mem_stage #(.REG_SIZE(RS), .ADDR_SIZE(AS), .REG_ADDR(RA)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .regwrite_in(regwrite_in),
    .memread(memread), .memwrite(memwrite), .aluresult(aluresult),
    .store_data(store_data), .wreg_in(wreg_in),
`ifdef MEM_BYTE_EN
    .byte_op(byte_op),
`endif
    .stall(stall), .regwrite_out(regwrite_out), .wreg_out(wreg_out),
    .memresult(memresult), .misaligned(misaligned), .mem_enable(mem_enable),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
`ifdef MEM_BYTE_EN
    .mem_be(mem_be),
`endif
    .mem_data_out(mem_data_out), .mem_ack(mem_ack), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid_in = 0; regwrite_in = 0; memread = 0; memwrite = 0;
    aluresult = '0; store_data = '0; wreg_in = '0;
`ifdef MEM_BYTE_EN
    byte_op = 0;
`endif
  endtask

  task automatic drive_op(input logic rw_in, input logic rd, input logic wr,
                          input logic [RS-1:0] a, input logic [RS-1:0] sd,
                          input logic [RA-1:0] r);
    valid_in = 1; regwrite_in = rw_in; memread = rd; memwrite = wr;
    aluresult = a; store_data = sd; wreg_in = r;
  endtask

  task automatic expect_wb(input logic [RA-1:0] r, input logic [RS-1:0] d);
    exp_q.push_back({r, d});
  endtask

  // monitor: every write-back or misaligned pulse must match an expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (regwrite_out) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected actual wreg=%0d data=0x%0h required none", wreg_out, memresult);
        end else begin
          chk("wb", {wreg_out, memresult}, exp_q.pop_front());
        end
      end
      if (misaligned) begin
        total++;
        if (exp_mis == 0) begin
          bad++;
          $display("FAIL misaligned_unexpected actual=1 required=0");
        end else begin
          exp_mis--;
        end
      end
    end
  end

  initial begin
    idle_inputs();
    mem_ack = 0; mem_data_out = '0;
    reset = 1;
    cyc(); cyc();
    neg();
    chk("rst_regwrite", regwrite_out, 0);
    chk("rst_memresult", memresult, 0);
    chk("rst_wreg", wreg_out, 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_state", dbg_state_o, 0);
    chk("rst_stall", stall, 0);
    cyc(); reset = 0;

    // ALU pass-through
    drive_op(1, 0, 0, 32'h1234, 0, 7);
    expect_wb(7, 32'h1234);
    neg(); chk("alu_stall", stall, 0);
    cyc();
    drive_op(0, 0, 0, 32'h5555, 0, 8);   // no regwrite: no write-back
    neg(); chk("alu_nowb_stall", stall, 0);
    cyc(); idle_inputs();
    neg(); chk("alu_nowb_regwrite", regwrite_out, 0);

    // load with ack in T+3
    cyc();
    drive_op(1, 1, 0, 32'h100, 0, 3);
    neg(); chk("ld_stall_T", stall, 1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (i == 3) begin mem_ack = 1; mem_data_out = 32'hDEADBEEF; expect_wb(3, 32'hDEADBEEF); end
      neg();
      chk("ld_mem_enable", mem_enable, 1);
      chk("ld_mem_addr", mem_addr, 32'h100);
      chk("ld_mem_rw", mem_rw, 0);
      chk("ld_stall", stall, (i < 3) ? 1 : 0);
    end
    cyc(); mem_ack = 0; idle_inputs();
    neg(); chk("ld_done_enable", mem_enable, 0);
    chk("ld_done_state", dbg_state_o, 0);

    // store, ack in T+1, then ALU op in T+2
    cyc();
    drive_op(1, 0, 1, 32'h40, 32'hCAFE0001, 12);
    neg(); chk("st_stall_T", stall, 1);
    cyc(); mem_ack = 1;
    neg();
    chk("st_mem_rw", mem_rw, 1);
    chk("st_mem_data_in", mem_data_in, 32'hCAFE0001);
    chk("st_mem_addr", mem_addr, 32'h40);
    chk("st_stall_ack", stall, 0);
    cyc(); mem_ack = 0;
    drive_op(1, 0, 0, 32'h55, 0, 9);
    expect_wb(9, 32'h55);
    neg();
    chk("st_next_stall", stall, 0);
    chk("st_regwrite", regwrite_out, 0);
    chk("st_done_enable", mem_enable, 0);
    cyc(); idle_inputs();

    // misaligned word load, then misaligned store
    cyc();
    drive_op(1, 1, 0, 32'h102, 0, 4);
    exp_mis++;
    neg(); chk("mis_stall", stall, 0);
    cyc();
    drive_op(0, 0, 1, 32'h43, 32'h77, 0);
    exp_mis++;
    neg();
    chk("mis_enable", mem_enable, 0);
    chk("mis_regwrite", regwrite_out, 0);
    cyc(); idle_inputs();
    neg(); chk("mis_st_enable", mem_enable, 0);
    cyc();
    neg(); chk("mis_pulse_end", misaligned, 0);

    // both read and write: load wins
    cyc();
    drive_op(0, 1, 1, 32'h80, 32'hFFFF, 6);
    cyc(); mem_ack = 1; mem_data_out = 32'h11112222; expect_wb(6, 32'h11112222);
    neg(); chk("rw_both_rw", mem_rw, 0);
    cyc(); mem_ack = 0; idle_inputs();

    // reset in T+2 of a pending load; later ack ignored
    cyc();
    drive_op(1, 1, 0, 32'h200, 0, 5);
    cyc();
    cyc(); reset = 1;
    cyc(); reset = 0; idle_inputs(); mem_ack = 1; mem_data_out = 32'h99;
    neg();
    chk("rmid_enable", mem_enable, 0);
    chk("rmid_state", dbg_state_o, 0);
    chk("rmid_addr", mem_addr, 0);
    chk("rmid_regwrite", regwrite_out, 0);
    chk("rmid_stall", stall, 0);
    cyc(); mem_ack = 0;
    neg(); chk("rmid_memresult", memresult, 0);

`ifdef MEM_BYTE_EN
    // byte load at 0x41
    cyc();
    drive_op(1, 1, 0, 32'h41, 0, 2); byte_op = 1;
    neg(); chk("bl_stall", stall, 1);
    cyc(); mem_ack = 1; mem_data_out = 32'h0000_8000; expect_wb(2, 32'hFFFF_FF80);
    neg();
    chk("bl_addr", mem_addr, 32'h40);
    chk("bl_be", mem_be, 4'b0010);
    cyc(); mem_ack = 0; idle_inputs();
    // byte store at 0x43
    cyc();
    drive_op(0, 0, 1, 32'h43, 32'h1234_56AB, 0); byte_op = 1;
    cyc(); mem_ack = 1;
    neg();
    chk("bs_addr", mem_addr, 32'h40);
    chk("bs_data", mem_data_in, 32'hABAB_ABAB);
    chk("bs_be", mem_be, 4'b1000);
    cyc(); mem_ack = 0; idle_inputs();
    // word store enables all lanes
    cyc();
    drive_op(0, 0, 1, 32'h44, 32'h0102_0304, 0);
    cyc(); mem_ack = 1;
    neg(); chk("ws_be", mem_be, 4'b1111);
    cyc(); mem_ack = 0; idle_inputs();
`endif

    cyc(); cyc();
    neg();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_mis_drained", exp_mis, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that sits directly downstream of `exec1`. It consumes the ALU result as an effective address, or passes it through unchanged for non-memory ops. It runs loads and stores over a single-outstanding request/acknowledge memory port and hands register write-back information (`regwrite_out`, `wreg_out`, `memresult`) to the write-back mux, which also merges the M5 multiply path. Upstream is held off with `stall` while a memory transaction is pending.

## Interface
Parameters:
- `REG_SIZE`, default 32, data word width.
- `ADDR_SIZE`, default 32, address width.
- `REG_ADDR`, default 5, register-index width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  op from `exec1` is present this cycle.
- `regwrite_in`  in  1  op writes a register (ALU op or load).
- `memread`  in  1  op is a load.
- `memwrite`  in  1  op is a store.
- `aluresult`  in  `REG_SIZE`  ALU result / effective address.
- `store_data`  in  `REG_SIZE`  store source value.
- `wreg_in`  in  `REG_ADDR`  destination register.
- `byte_op`  in  1  byte access (only with `MEM_BYTE_EN`).
- `stall`  out  1  combinational; upstream holds its op when high.
- `regwrite_out`  out  1  write-back enable, registered.
- `wreg_out`  out  `REG_ADDR`  write-back register, registered.
- `memresult`  out  `REG_SIZE`  write-back data, registered.
- `misaligned`  out  1  one-cycle pulse on a misaligned word access.
- `mem_enable`  out  1  memory request, held high until ack.
- `mem_rw`  out  1  1 = write, 0 = read.
- `mem_addr`  out  `ADDR_SIZE`  word-aligned request address.
- `mem_data_in`  out  `REG_SIZE`  store data toward memory.
- `mem_be`  out  4  byte enables (only with `MEM_BYTE_EN`).
- `mem_data_out`  in  `REG_SIZE`  read data from memory.
- `mem_ack`  in  1  memory completes the request this cycle.

## Operation
- FSM states:
  - IDLE: accepts a new op.
  - WAIT: a request is outstanding.
- Memory op definition: `memop = valid_in & (memread | memwrite)`.
- Precedence: `memread` wins if both `memread` and `memwrite` are high; `regwrite_in` is ignored for stores.
- IDLE, `valid_in`, no memop: register the ALU result for write-back.
  - `regwrite_out = regwrite_in`, `memresult = aluresult`, `wreg_out = wreg_in`.
- IDLE, memop, word access with `aluresult[1:0] != 0`: no request is issued.
  - `misaligned` is high for 1 cycle and `regwrite_out` is 0.
  - The FSM stays in IDLE.
- IDLE, memop, aligned: latch the request, raise `mem_enable`, and go to WAIT.
  - Latched fields: address, `mem_rw`, store data, `wreg_in`, and the load flag.
- WAIT, `mem_ack` = 0: hold all `mem_*` outputs stable.
- WAIT, `mem_ack` = 1: drop `mem_enable` and go to IDLE.
  - Load: `regwrite_out = 1`, `memresult = mem_data_out`, `wreg_out` = latched register.
  - Store: `regwrite_out = 0`.
- `stall = (IDLE & memop & aligned) | (WAIT & ~mem_ack)`.
  - The upstream op advances on the same edge that completes the transaction, so it is never accepted twice.
- `regwrite_out` and `misaligned` are 0 in any cycle that is not described above.
- A `mem_ack` that arrives while in IDLE is ignored.

## Timing
- Reset values: state IDLE; `regwrite_out`, `wreg_out`, `memresult`, `misaligned`, `mem_enable`, `mem_rw`, `mem_addr`, `mem_data_in` all 0; `mem_be` = 0.
- Pass-through latency: 1 cycle, with no stall.
- Memory op accepted in cycle T:
  - `stall` is high in T.
  - `mem_enable` is high from T+1.
  - `mem_ack` is sampled from T+1 onward.
  - If the ack arrives in cycle A, write-back outputs are valid and `mem_enable` is 0 in A+1.
- Minimum load latency: 2 cycles, when `mem_ack` arrives in T+1.
- Reset mid-transaction: the request is abandoned and every output returns to its reset value on the next edge.

## Configuration
- `MEM_BYTE_EN` defined:
  - `byte_op` and `mem_be` exist.
  - Byte accesses are never misaligned.
  - `mem_addr = {aluresult[ADDR_SIZE-1:2], 2'b00}` for all accesses.
  - Lane select is `aluresult[1:0]`, little-endian.
  - Byte loads sign-extend the selected lane of `mem_data_out`.
  - Byte stores replicate `store_data[7:0]` into all four lanes, with `mem_be` one-hot on the selected lane.
  - Word accesses drive `mem_be = 4'b1111`.
- `MEM_BYTE_EN` undefined:
  - `byte_op` and `mem_be` are absent.
  - Every access is a 32-bit word.
  - The misalignment check always applies.

## Test plan
- ALU pass-through: `valid_in=1`, `regwrite_in=1`, `aluresult=0x1234`, `wreg_in=7` -> next cycle `regwrite_out=1`, `memresult=0x1234`, `wreg_out=7`, `stall` never high.
- Load with a 3-cycle ack delay: load at address 0x100, `wreg_in=3`, `mem_ack` in T+3 with `mem_data_out=0xDEADBEEF` -> `mem_addr=0x100` and `mem_rw=0` during T+1..T+3, `stall` high T..T+2, T+4 `regwrite_out=1`, `memresult=0xDEADBEEF`, `wreg_out=3`.
- Store: store `0xCAFE0001` to address 0x40, ack in T+1 -> `mem_rw=1`, `mem_data_in=0xCAFE0001`, `regwrite_out` stays 0, and a following ALU op is accepted in T+2.
- Misaligned word load at address 0x102 -> `misaligned=1` for 1 cycle, `mem_enable` stays 0, `regwrite_out=0`.
- Reset in cycle T+2 of a pending load -> T+3 `mem_enable=0`, state IDLE; a later ack causes no write-back.
- Byte load, `MEM_BYTE_EN` defined: address 0x41, `mem_data_out=0x0000_8000` -> `mem_addr=0x40`, `memresult=0xFFFF_FF80`.
